// File: rtl/fwd_scoreboard.sv
// Operand forwarding scoreboard: tracks DEPTH producer stages and resolves each source to RF or youngest match.
// Zero-cycle combinational forwarding; stall held while the selected producer is an outstanding load.
module fwd_scoreboard #(
  parameter int XLEN     = 32,
  parameter int NSRC     = 2,
  parameter int DEPTH    = 2,
  parameter int LD_STAGE = 1,
  localparam int SELW    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NSRC-1:0]        src_valid,
  input  logic [NSRC*5-1:0]      src_addr,
  input  logic [NSRC*XLEN-1:0]   src_rf_data,
  input  logic                   ex_valid,
  input  logic                   ex_we,
  input  logic                   ex_load,
  input  logic [4:0]             ex_rd,
  input  logic [XLEN-1:0]        ex_result,
  input  logic                   ld_valid,
  input  logic [XLEN-1:0]        ld_data,
  input  logic                   flush,
  output logic [NSRC*XLEN-1:0]   op_out,
  output logic [NSRC*SELW-1:0]   fwd_sel,
  output logic                   stall,
  output logic [15:0]            stall_cnt
);

  logic [DEPTH-1:0] e_valid;
  logic [DEPTH-1:0] e_we;
  logic [DEPTH-1:0] e_ready;
  logic [4:0]       e_rd   [DEPTH];
  logic [XLEN-1:0]  e_data [DEPTH];

  logic capture;
  assign capture = ex_valid && !stall && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        e_valid[k] <= 1'b0;
        e_we[k]    <= 1'b0;
        e_ready[k] <= 1'b1;
        e_rd[k]    <= 5'd0;
        e_data[k]  <= '0;
      end
      stall_cnt <= 16'd0;
    end else begin
      if (capture) begin
        e_valid[0] <= 1'b1;
        e_we[0]    <= ex_we;
        e_ready[0] <= !ex_load;
        e_rd[0]    <= ex_rd;
        e_data[0]  <= ex_result;
      end else begin
        e_valid[0] <= 1'b0;
        e_we[0]    <= 1'b0;
        e_ready[0] <= 1'b1;
        e_rd[0]    <= 5'd0;
        e_data[0]  <= '0;
      end
      for (int k = 1; k < DEPTH; k++) begin
        e_valid[k] <= e_valid[k-1];
        e_we[k]    <= e_we[k-1];
        e_rd[k]    <= e_rd[k-1];
        // Load data is merged only as the pending entry moves into the return stage.
        if (k == LD_STAGE && e_valid[k-1] && !e_ready[k-1] && ld_valid) begin
          e_data[k]  <= ld_data;
          e_ready[k] <= 1'b1;
        end else begin
          e_data[k]  <= e_data[k-1];
          e_ready[k] <= e_ready[k-1];
        end
      end
      if (stall && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  always_comb begin
    logic [4:0] a;
    logic       rdy;
    op_out  = src_rf_data;
    fwd_sel = '0;
    stall   = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      a   = src_addr[5*i +: 5];
      rdy = 1'b1;
      // Walk oldest to youngest so the youngest match overrides.
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (e_valid[k] && e_we[k] && e_rd[k] == a && a != 5'd0 && src_valid[i]) begin
          fwd_sel[SELW*i +: SELW] = SELW'(k + 1);
          op_out[XLEN*i +: XLEN]  = e_data[k];
          rdy                     = e_ready[k];
        end
      end
      if (!rdy)
        stall = 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard at default parameters (XLEN 32, NSRC 2, DEPTH 2, LD_STAGE 1).
module tb_fwd_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  src_valid;
  logic [9:0]  src_addr;
  logic [63:0] src_rf_data;
  logic        ex_valid, ex_we, ex_load;
  logic [4:0]  ex_rd;
  logic [31:0] ex_result;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        flush;
  logic [63:0] op_out;
  logic [3:0]  fwd_sel;
  logic        stall;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  fwd_scoreboard dut (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_addr(src_addr), .src_rf_data(src_rf_data),
    .ex_valid(ex_valid), .ex_we(ex_we), .ex_load(ex_load),
    .ex_rd(ex_rd), .ex_result(ex_result),
    .ld_valid(ld_valid), .ld_data(ld_data), .flush(flush),
    .op_out(op_out), .fwd_sel(fwd_sel), .stall(stall), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ex(input logic v, input logic we, input logic ld,
                    input logic [4:0] rd, input logic [31:0] res);
    ex_valid = v; ex_we = we; ex_load = ld; ex_rd = rd; ex_result = res;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    ex(0, 0, 0, 0, 0);
    ld_valid = 0; ld_data = 0; flush = 0;
    src_valid = 2'b11;
    src_addr = {5'd6, 5'd5};
    src_rf_data = {32'h66, 32'h11};
    #2;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_sel", 32'(fwd_sel), 0);
    chk("rst_op0", op_out[31:0], 32'h11);
    chk("rst_op1", op_out[63:32], 32'h66);
    chk("rst_cnt", 32'(stall_cnt), 0);
    tick();
    rst = 1'b0;

    // C1: addi x5 = 0x10 in EX
    ex(1, 1, 0, 5, 32'h10);
    src_valid = 2'b00;
    tick();

    // C2: consumer of x5 (also producing x5 = 0xA)
    src_valid = 2'b11;
    ex(1, 1, 0, 5, 32'hA);
    #3;
    chk("b2b_sel", 32'(fwd_sel[1:0]), 1);
    chk("b2b_op", op_out[31:0], 32'h10);
    chk("b2b_stall", 32'(stall), 0);
    chk("b2b_sel1", 32'(fwd_sel[3:2]), 0);
    chk("b2b_op1", op_out[63:32], 32'h66);
    tick();

    // C3: entry0 = x5/0xA, entry1 = x5/0x10; EX produces x5 = 0xB
    ex(1, 1, 0, 5, 32'hB);
    #3;
    chk("pri_a_op", op_out[31:0], 32'hA);
    tick();

    // C4: entry0 = 0xB, entry1 = 0xA; source 1 reads x5 but is not used
    ex(0, 0, 0, 0, 0);
    src_addr = {5'd5, 5'd5};
    src_valid = 2'b01;
    #3;
    chk("pri_sel", 32'(fwd_sel[1:0]), 1);
    chk("pri_op", op_out[31:0], 32'hB);
    chk("srcv_sel1", 32'(fwd_sel[3:2]), 0);
    chk("srcv_op1", op_out[63:32], 32'h66);
    tick();

    // C5: x5 = 0xB aged into entry1
    #3;
    chk("age_sel", 32'(fwd_sel[1:0]), 2);
    chk("age_op", op_out[31:0], 32'hB);
    tick();

    // C6: x5 drained; load x7 in EX
    ex(1, 1, 1, 7, 32'h1234);
    #3;
    chk("drain_sel", 32'(fwd_sel[1:0]), 0);
    chk("drain_op", op_out[31:0], 32'h11);
    tick();

    // C7: load-use on x7; load data returns during this cycle
    src_addr[4:0] = 5'd7;
    ex(1, 1, 0, 8, 32'h77);
    ld_valid = 1; ld_data = 32'hDEAD;
    #3;
    chk("lu_stall", 32'(stall), 1);
    chk("lu_sel_pend", 32'(fwd_sel[1:0]), 1);
    tick();
    ld_valid = 0;

    // C8: replayed consumer sees the load data in entry1
    #3;
    chk("lu_cnt", 32'(stall_cnt), 1);
    chk("lu_stall_clr", 32'(stall), 0);
    chk("lu_sel", 32'(fwd_sel[1:0]), 2);
    chk("lu_op", op_out[31:0], 32'hDEAD);
    tick();

    // C9: replayed consumer's x8 result forwarded; EX writes x0
    src_addr[4:0] = 5'd8;
    ex(1, 1, 0, 0, 32'h55);
    #3;
    chk("x8_sel", 32'(fwd_sel[1:0]), 1);
    chk("x8_op", op_out[31:0], 32'h77);
    tick();

    // C10: consumer of x0; flushed producer x3 = 9 in EX
    src_addr[4:0] = 5'd0;
    src_rf_data[31:0] = 32'hCAFE;
    ex(1, 1, 0, 3, 32'h9);
    flush = 1;
    #3;
    chk("x0_sel", 32'(fwd_sel[1:0]), 0);
    chk("x0_op", op_out[31:0], 32'hCAFE);
    chk("x0_stall", 32'(stall), 0);
    tick();
    flush = 0;

    // C11: consumer of flushed x3; load x9 in EX
    src_addr[4:0] = 5'd3;
    ex(1, 1, 1, 9, 32'h0);
    #3;
    chk("flush_sel", 32'(fwd_sel[1:0]), 0);
    chk("flush_op", op_out[31:0], 32'hCAFE);
    tick();

    // C12: load-use on x9 with flush asserted together with stall
    src_addr[4:0] = 5'd9;
    ex(1, 1, 0, 10, 32'h1);
    flush = 1;
    #3;
    chk("fs_stall", 32'(stall), 1);
    tick();
    flush = 0;

    // C13: x9 still pending in entry1 (no load data); entry0 must be a bubble
    src_addr[9:5] = 5'd10;
    src_valid = 2'b11;
    #3;
    chk("fs_cnt", 32'(stall_cnt), 2);
    chk("fs_sel", 32'(fwd_sel[1:0]), 2);
    chk("fs_stall2", 32'(stall), 1);
    chk("fs_bubble_sel1", 32'(fwd_sel[3:2]), 0);
    rst = 1;
    #1;
    chk("mid_rst_stall", 32'(stall), 0);
    chk("mid_rst_cnt", 32'(stall_cnt), 0);
    chk("mid_rst_sel", 32'(fwd_sel), 0);
    chk("mid_rst_op", op_out[31:0], 32'hCAFE);
    #1;
    rst = 0;
    tick();

    // C14: first edge after reset captured x10 = 1
    #3;
    chk("first_cap_sel1", 32'(fwd_sel[3:2]), 1);
    chk("first_cap_op1", op_out[63:32], 32'h1);
    chk("first_cap_sel0", 32'(fwd_sel[1:0]), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
